// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, sequencer op codes and controller states.
// Imported by the execute-stage ALU, the sequencer and their testbenches.
package alu_pkg;

  localparam int ALU_W = 8;
  localparam int RES_W = 2 * ALU_W;

  typedef enum logic [3:0] {
    FN_ADD  = 4'b0000,
    FN_ADDC = 4'b0001,
    FN_SUB  = 4'b0010,
    FN_SUBC = 4'b0011,
    FN_AND  = 4'b0100,
    FN_OR   = 4'b0101,
    FN_XOR  = 4'b0110,
    FN_MASK = 4'b0111,
    FN_SHL  = 4'b1000,
    FN_SHR  = 4'b1001,
    FN_ROL  = 4'b1010,
    FN_ROR  = 4'b1011
  } alu_fn_e;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_ADD16 = 2'b01,
    OP_SUB16 = 2'b10,
    OP_RSVD  = 2'b11
  } seq_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_LO   = 3'd2,
    S_HI   = 3'd3,
    S_DONE = 3'd4
  } seq_state_e;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/result handshake between a requester and the multi-cycle ALU sequencer.
// The requester holds its request until start_ready is high.
interface alu_seq_ctrl_if;

  logic        start_valid;
  logic        start_ready;
  logic [1:0]  op;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] res;
  logic        res_cout;
  logic        res_zero;
  logic        res_valid;

  modport master (
    output start_valid, op, op_a, op_b,
    input  start_ready, res, res_cout, res_zero, res_valid
  );

  modport slave (
    input  start_valid, op, op_a, op_b,
    output start_ready, res, res_cout, res_zero, res_valid
  );

endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer driving the shared 8-bit ALU for 8x8 multiply, 16-bit add and
// 16-bit subtract. All ALU inputs are registered so fn, operands and carry-in change together.
module alu_seq_ctrl
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  alu_seq_ctrl_if.slave bus,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_fn,
  output logic [2:0]  alu_sc,
  output logic        alu_cin,
  input  logic [7:0]  alu_y,
  input  logic        alu_cout,
  input  logic        alu_zero
);

  seq_state_e  state;
  logic [2:0]  cnt;
  logic [7:0]  mcand;
  logic [7:0]  lo;
  logic [7:0]  a_hi;
  logic [7:0]  b_hi;
  logic        accept;
  logic [15:0] mul_res;
  logic [15:0] add_res;
  logic        unused_alu_zero;

  // The ALU zero flag reflects only one byte, so the 16-bit zero flag is rebuilt here.
  assign unused_alu_zero = alu_zero;

  assign bus.start_ready = (state == S_IDLE) || (state == S_DONE);
  assign accept          = bus.start_valid && bus.start_ready && (bus.op != OP_RSVD);
  assign alu_sc          = 3'd0;

  // Product after the final shift-add step, and the 16-bit sum after the HI byte.
  assign mul_res = {alu_cout, alu_y, lo[7:1]};
  assign add_res = {alu_y, lo};

  // NOTE: all state here uses non-blocking assignments so every flop samples the
  // pre-edge values of the others, matching the hardware regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are reset too; the whole block is a handful of
      // flops and a clean post-reset ALU drive matters more than the reset fan-out.
      state         <= S_IDLE;
      cnt           <= 3'd0;
      mcand         <= 8'h00;
      lo            <= 8'h00;
      a_hi          <= 8'h00;
      b_hi          <= 8'h00;
      alu_fn        <= FN_ADD;
      alu_a         <= 8'h00;
      alu_b         <= 8'h00;
      alu_cin       <= 1'b0;
      bus.res       <= 16'h0000;
      bus.res_cout  <= 1'b0;
      bus.res_zero  <= 1'b1;
      bus.res_valid <= 1'b0;
    end else begin
      bus.res_valid <= 1'b0;

      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            alu_cin <= 1'b0;
            if (bus.op == OP_MUL) begin
              state  <= S_MUL;
              cnt    <= 3'd0;
              mcand  <= bus.op_a[7:0];
              lo     <= bus.op_b[7:0];
              alu_fn <= FN_ADD;
              alu_a  <= 8'h00;
              alu_b  <= bus.op_b[0] ? bus.op_a[7:0] : 8'h00;
            end else begin
              state  <= S_LO;
              a_hi   <= bus.op_a[15:8];
              b_hi   <= bus.op_b[15:8];
              alu_fn <= (bus.op == OP_SUB16) ? FN_SUB : FN_ADD;
              alu_a  <= bus.op_a[7:0];
              alu_b  <= bus.op_b[7:0];
            end
          end else begin
            state <= S_IDLE;
          end
        end

        S_MUL: begin
          // alu_a carries the running high byte; lo shifts right taking the sum LSB.
          lo  <= {alu_y[0], lo[7:1]};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state         <= S_DONE;
            bus.res       <= mul_res;
            bus.res_cout  <= 1'b0;
            bus.res_zero  <= (mul_res == 16'h0000);
            bus.res_valid <= 1'b1;
            alu_fn        <= FN_ADD;
            alu_a         <= 8'h00;
            alu_b         <= 8'h00;
          end else begin
            alu_a <= {alu_cout, alu_y[7:1]};
            alu_b <= lo[1] ? mcand : 8'h00;
          end
        end

        S_LO: begin
          state   <= S_HI;
          lo      <= alu_y;
          alu_fn  <= (alu_fn == FN_SUB) ? FN_SUBC : FN_ADDC;
          alu_a   <= a_hi;
          alu_b   <= b_hi;
          alu_cin <= alu_cout;
        end

        S_HI: begin
          state         <= S_DONE;
          bus.res       <= add_res;
          bus.res_cout  <= alu_cout;
          bus.res_zero  <= (add_res == 16'h0000);
          bus.res_valid <= 1'b1;
          alu_fn        <= FN_ADD;
          alu_a         <= 8'h00;
          alu_b         <= 8'h00;
          alu_cin       <= 1'b0;
        end

        default: begin
          state   <= S_IDLE;
          alu_fn  <= FN_ADD;
          alu_a   <= 8'h00;
          alu_b   <= 8'h00;
          alu_cin <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a small behavioural 8-bit ALU beside it.
// Expected results are hand-computed constants.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] alu_a, alu_b, alu_y;
  logic [3:0] alu_fn;
  logic [2:0] alu_sc;
  logic       alu_cin, alu_cout, alu_zero;

  int total = 0;
  int bad   = 0;

  alu_seq_ctrl_if bus ();

  alu_seq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_fn   (alu_fn),
    .alu_sc   (alu_sc),
    .alu_cin  (alu_cin),
    .alu_y    (alu_y),
    .alu_cout (alu_cout),
    .alu_zero (alu_zero)
  );

  always #5 clk = ~clk;

  // Arithmetic subset of the shared ALU; cout is the borrow for subtraction.
  always_comb begin
    logic [8:0] t;
    t = 9'h000;
    case (alu_fn)
      4'b0000: t = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0001: t = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
      4'b0010: t = {1'b0, alu_a} - {1'b0, alu_b};
      4'b0011: t = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_cin};
      default: t = 9'h000;
    endcase
    alu_y    = t[7:0];
    alu_cout = t[8];
    alu_zero = (t[7:0] == 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the controller ready; returns at the negedge showing res_valid.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] er, input logic ec,
                        input int elat, input logic ehc);
    int         lat;
    logic       bad_fn;
    logic [3:0] fn2;
    logic       cin2;
    lat    = -1;
    bad_fn = 1'b0;
    fn2    = 4'hF;
    cin2   = 1'b0;
    check({tag, "_ready"}, 32'(bus.start_ready), 32'd1);
    bus.start_valid = 1'b1;
    bus.op          = o;
    bus.op_a        = a;
    bus.op_b        = b;
    @(posedge clk);
    #1 bus.start_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 2) begin
        fn2  = alu_fn;
        cin2 = alu_cin;
      end
      if (bus.res_valid) begin
        lat = i;
        break;
      end
      if (alu_fn != 4'b0000) bad_fn = 1'b1;
    end
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_res"}, 32'(bus.res), 32'(er));
    check({tag, "_cout"}, 32'(bus.res_cout), 32'(ec));
    check({tag, "_zero"}, 32'(bus.res_zero), 32'(er == 16'h0000));
    if (o == OP_MUL) begin
      check({tag, "_fn_add"}, 32'(bad_fn), 32'd0);
    end else begin
      check({tag, "_hi_fn"}, 32'(fn2), (o == OP_ADD16) ? 32'h1 : 32'h3);
      check({tag, "_hi_cin"}, 32'(cin2), 32'(ehc));
    end
  endtask

  initial begin
    int   seen;
    logic ok;
    bus.start_valid = 1'b0;
    bus.op          = 2'b00;
    bus.op_a        = 16'h0000;
    bus.op_b        = 16'h0000;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.start_ready), 32'd1);
    check("rst_res", 32'(bus.res), 32'h0);
    check("rst_cout", 32'(bus.res_cout), 32'd0);
    check("rst_zero", 32'(bus.res_zero), 32'd1);
    check("rst_valid", 32'(bus.res_valid), 32'd0);
    check("rst_alu", 32'({alu_fn, alu_a, alu_b, alu_sc, alu_cin}), 32'h0);

    run_op("mul_0d_0b", OP_MUL, 16'h000D, 16'h000B, 16'h008F, 1'b0, 9, 1'b0);
    @(negedge clk);
    check("mul_pulse", 32'(bus.res_valid), 32'd0);
    check("mul_hold", 32'(bus.res), 32'h008F);
    run_op("mul_ff_ff", OP_MUL, 16'h12FF, 16'h34FF, 16'hFE01, 1'b0, 9, 1'b0);
    @(negedge clk);
    run_op("mul_00_5a", OP_MUL, 16'h0000, 16'h005A, 16'h0000, 1'b0, 9, 1'b0);
    @(negedge clk);
    run_op("add_ffff_1", OP_ADD16, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 3, 1'b1);
    @(negedge clk);
    run_op("sub_1000_1", OP_SUB16, 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 3, 1'b1);
    @(negedge clk);
    run_op("sub_0000_1", OP_SUB16, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 3, 1'b1);
    @(negedge clk);

    // Abort a multiply in its fourth ALU cycle.
    bus.start_valid = 1'b1;
    bus.op          = OP_MUL;
    bus.op_a        = 16'h00FF;
    bus.op_b        = 16'h00FF;
    @(posedge clk);
    #1 bus.start_valid = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(bus.start_ready), 32'd1);
    check("abort_res", 32'(bus.res), 32'h0);
    check("abort_zero", 32'(bus.res_zero), 32'd1);
    repeat (10) begin
      if (bus.res_valid) seen++;
      @(negedge clk);
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    run_op("add_after_rst", OP_ADD16, 16'h1234, 16'h1111, 16'h2345, 1'b0, 3, 1'b0);
    @(negedge clk);

    // Reserved op must be ignored.
    bus.start_valid = 1'b1;
    bus.op          = OP_RSVD;
    bus.op_a        = 16'h5555;
    bus.op_b        = 16'h0101;
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (!bus.start_ready || bus.res_valid || alu_fn != 4'b0000) ok = 1'b0;
    end
    bus.start_valid = 1'b0;
    check("rsvd_ignored", 32'(ok), 32'd1);
    check("rsvd_res_held", 32'(bus.res), 32'h2345);

    // Second request accepted in DONE of the first.
    run_op("b2b_first", OP_ADD16, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 3, 1'b1);
    run_op("b2b_second", OP_ADD16, 16'h8000, 16'h8000, 16'h0000, 1'b1, 3, 1'b0);
    @(negedge clk);
    check("b2b_pulse", 32'(bus.res_valid), 32'd0);
    check("b2b_idle", 32'(bus.start_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
